// File: rtl/dvs_ravens_pkg.sv
// Shared types and widths for the DVS camera receive path.
package dvs_ravens_pkg;

  localparam int unsigned AER_BITS = 10;
  localparam int unsigned X_BITS   = 9;
  localparam int unsigned Y_BITS   = 10;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACK,
    RECOVER
  } aer_rx_state_t;

  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              pol;
  } dvs_pix_event_t;

endpackage

// File: rtl/aer_req_sync.sv
// N-flop single-bit synchroniser for the asynchronous camera request.
module aer_req_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/dvs_aer_rx_frontend.sv
// AER receive front end: 4-phase req/ack handshake, row/column pairing into
// pixel events, one-deep output register, orphan and timeout fault counters.
module dvs_aer_rx_frontend
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_BITS       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AER_BITS-1:0] aer,
  input  logic                xsel,
  input  logic                req,
  output logic                ack,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [X_BITS-1:0]   ev_x,
  output logic [Y_BITS-1:0]   ev_y,
  output logic                ev_pol,
  output logic [CNT_BITS-1:0] orphan_cnt,
  output logic [CNT_BITS-1:0] timeout_cnt
);

  localparam int unsigned         TMR_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

  aer_rx_state_t        state, state_n;
  logic                 req_s;
  logic [AER_BITS-1:0]  cap_aer;
  logic                 cap_xsel;
  logic [Y_BITS-1:0]    row_reg;
  logic                 row_valid;
  logic [TMR_BITS-1:0]  timer;
  dvs_pix_event_t       ev_reg;

  logic cap_en, row_load, ev_load, ev_drain;
  logic orphan_inc, timeout_inc, timer_inc, slot_free;

  aer_req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );

  assign slot_free = !ev_valid || ev_ready;

  always_comb begin
    state_n     = state;
    cap_en      = 1'b0;
    row_load    = 1'b0;
    ev_load     = 1'b0;
    orphan_inc  = 1'b0;
    timeout_inc = 1'b0;
    timer_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          cap_en  = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (!cap_xsel) begin
          row_load = 1'b1;
          state_n  = ACK;
        end else if (!row_valid) begin
          orphan_inc = 1'b1;
          state_n    = ACK;
        end else if (slot_free) begin
          ev_load = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_n = IDLE;
        end else if (timer == TMR_LAST) begin
          timeout_inc = 1'b1;
          state_n     = RECOVER;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RECOVER: begin
        if (!req_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ev_drain = ev_valid && ev_ready && !ev_load;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ack is high exactly while the FSM sits in ACK, registered from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack         <= 1'b0;
      cap_aer     <= '0;
      cap_xsel    <= 1'b0;
      row_reg     <= '0;
      row_valid   <= 1'b0;
      timer       <= '0;
      ev_valid    <= 1'b0;
      ev_reg      <= '0;
      orphan_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      ack <= (state_n == ACK);
      if (cap_en) begin
        cap_aer  <= aer;
        cap_xsel <= xsel;
      end
      if (row_load) begin
        row_reg   <= cap_aer;
        row_valid <= 1'b1;
      end
      if (timer_inc) timer <= timer + TMR_BITS'(1);
      else           timer <= '0;
      if (ev_load) begin
        ev_valid   <= 1'b1;
        ev_reg.x   <= cap_aer[AER_BITS-1:1];
        ev_reg.y   <= row_reg;
        ev_reg.pol <= cap_aer[0];
      end else if (ev_drain) begin
        ev_valid <= 1'b0;
      end
      if (orphan_inc && orphan_cnt != '1)
        orphan_cnt <= orphan_cnt + CNT_BITS'(1);
      if (timeout_inc && timeout_cnt != '1)
        timeout_cnt <= timeout_cnt + CNT_BITS'(1);
    end
  end

  assign ev_x   = ev_reg.x;
  assign ev_y   = ev_reg.y;
  assign ev_pol = ev_reg.pol;

endmodule

// File: tb/tb_dvs_aer_rx_frontend.sv
// Self-checking bench for dvs_aer_rx_frontend: directed handshakes plus a
// randomized phase checked against a queue-based event model.
module tb_dvs_aer_rx_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  aer = '0;
  logic        xsel = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [8:0]  ev_x;
  logic [9:0]  ev_y;
  logic        ev_pol;
  logic [15:0] orphan_cnt;
  logic [15:0] timeout_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: pairing rules only, no handshake timing.
  bit          row_valid_m = 0;
  logic [9:0]  row_m = '0;
  int          orphan_m = 0;
  int          timeout_m = 0;
  logic [19:0] exp_q[$];
  int          n_events = 0;

  bit          hold_prev = 0;
  logic [19:0] prev_ev = '0;
  bit          rand_ready = 0;

  always #5 clk = ~clk;

  dvs_aer_rx_frontend #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (1024),
    .CNT_BITS       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aer         (aer),
    .xsel        (xsel),
    .req         (req),
    .ack         (ack),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_x        (ev_x),
    .ev_y        (ev_y),
    .ev_pol      (ev_pol),
    .orphan_cnt  (orphan_cnt),
    .timeout_cnt (timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [9:0] a, input logic x);
    logic [9:0] w;
    w = a;
    if (!x) begin
      row_valid_m = 1;
      row_m       = w;
    end else if (!row_valid_m) begin
      orphan_m++;
    end else begin
      exp_q.push_back({w[9:1], row_m, w[0]});
    end
  endtask

  task automatic model_reset();
    row_valid_m = 0;
    orphan_m    = 0;
    timeout_m   = 0;
    exp_q.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input int bound, output int n);
    n = 0;
    while (ack !== lvl && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_wait", ack, lvl);
  endtask

  task automatic send_word(input logic [9:0] a, input logic x, input bit chk_lat);
    int n;
    model_word(a, x);
    @(posedge clk);
    #1;
    aer  = a;
    xsel = x;
    req  = 1'b1;
    wait_ack(1'b1, 3000, n);
    if (chk_lat) chk("ack_latency", n, 4);
    req = 1'b0;
    wait_ack(1'b0, 3000, n);
  endtask

  task automatic drain();
    int n;
    ev_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    step(2);
    chk("queue_drained", exp_q.size(), 0);
    chk("valid_after_drain", ev_valid, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: in-order event check and hold-stability check.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", ev_valid, 1);
        chk("hold_data", {ev_x, ev_y, ev_pol}, prev_ev);
      end
      if (ev_valid && ev_ready) begin
        chk("event_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("event_data", {ev_x, ev_y, ev_pol}, exp_q.pop_front());
          n_events++;
        end
      end
      hold_prev = ev_valid && !ev_ready;
      prev_ev   = {ev_x, ev_y, ev_pol};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    logic [9:0] a;
    logic x;

    // Reset state
    step(3);
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_evdata", {ev_x, ev_y, ev_pol}, 0);
    chk("rst_orphan", orphan_cnt, 0);
    chk("rst_timeout", timeout_cnt, 0);

    // Row 37 then column x=100 pol=1
    ev_ready = 1'b1;
    send_word(10'd37, 1'b0, 1);
    send_word({9'd100, 1'b1}, 1'b1, 1);
    step(3);
    chk("first_event_count", n_events, 1);

    // Burst: row 5, columns 1,2,3
    send_word(10'd5, 1'b0, 1);
    for (int i = 1; i <= 3; i++) send_word({9'(i), 1'b0}, 1'b1, 1);
    step(3);
    chk("burst_event_count", n_events, 4);
    chk("burst_orphan", orphan_cnt, 0);
    drain();

    // Orphan column right after reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_reset();
    send_word({9'd50, 1'b1}, 1'b1, 1);
    step(2);
    chk("orphan_cnt", orphan_cnt, orphan_m);
    chk("orphan_no_event", ev_valid, 0);

    // Backpressure: first event held, second word stalls in DECODE
    ev_ready = 1'b0;
    send_word(10'd7, 1'b0, 1);
    send_word({9'd11, 1'b0}, 1'b1, 1);
    step(5);
    chk("held_valid", ev_valid, 1);
    chk("held_data", {ev_x, ev_y, ev_pol}, {9'd11, 10'd7, 1'b0});
    model_word({9'd22, 1'b1}, 1'b1);
    aer  = {9'd22, 1'b1};
    xsel = 1'b1;
    req  = 1'b1;
    step(12);
    chk("stall_ack_low", ack, 0);
    chk("stall_data", {ev_x, ev_y, ev_pol}, {9'd11, 10'd7, 1'b0});
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    wait_ack(1'b1, 50, n);
    chk("second_valid", ev_valid, 1);
    chk("second_data", {ev_x, ev_y, ev_pol}, {9'd22, 10'd7, 1'b1});
    req = 1'b0;
    wait_ack(1'b0, 50, n);
    drain();

    // Handshake timeout with req held high
    model_word(10'd300, 1'b0);
    step(1);
    aer  = 10'd300;
    xsel = 1'b0;
    req  = 1'b1;
    wait_ack(1'b1, 50, n);
    hi = 1;
    n  = 0;
    while (n < 1200) begin
      step(1);
      n++;
      if (!ack) break;
      hi++;
    end
    timeout_m++;
    chk("timeout_ack_cycles", hi, 1024);
    hi = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (ack) hi++;
    end
    chk("no_recapture", hi, 0);
    chk("timeout_cnt", timeout_cnt, timeout_m);
    req = 1'b0;
    step(10);
    chk("recover_ack_low", ack, 0);
    send_word({9'd33, 1'b0}, 1'b1, 1);
    step(3);
    chk("post_timeout_queue", exp_q.size(), 0);

    // Reset while ack=1 and ev_valid=1; req left high is recaptured
    ev_ready = 1'b0;
    send_word(10'd9, 1'b0, 1);
    model_word({9'd44, 1'b0}, 1'b1);
    step(1);
    aer  = {9'd44, 1'b0};
    xsel = 1'b1;
    req  = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("pre_rst_valid", ev_valid, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_reset();
    chk("midrst_ack", ack, 0);
    chk("midrst_valid", ev_valid, 0);
    chk("midrst_orphan", orphan_cnt, 0);
    chk("midrst_timeout", timeout_cnt, 0);
    model_word({9'd44, 1'b0}, 1'b1);
    wait_ack(1'b1, 50, n);
    chk("recapture_orphan", orphan_cnt, orphan_m);
    req = 1'b0;
    wait_ack(1'b0, 50, n);
    send_word({9'd45, 1'b0}, 1'b1, 1);
    step(2);
    chk("rowvalid_cleared", orphan_cnt, orphan_m);

    // Randomized words with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      a = 10'($urandom_range(0, 1023));
      x = ($urandom_range(0, 3) != 0);
      send_word(a, x, 0);
    end
    rand_ready = 0;
    step(1);
    drain();
    chk("rand_orphan", orphan_cnt, orphan_m);
    chk("rand_timeout", timeout_cnt, timeout_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvs_aer_rx_frontend.md
Name: dvs_aer_rx_frontend

Overview:
Asynchronous AER receive front end that sits directly upstream of the AER-to-event stage. It synchronises the camera's 4-phase req/ack handshake and pairs row words (xsel=0) with column words (xsel=1) into complete pixel events. Events leave on a one-deep valid/ready output register, and the camera is stalled via ack when that register is occupied. It also detects protocol faults: orphan column words and handshake timeouts.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the req synchroniser (minimum 2)
TIMEOUT_CYCLES, 1024, cycles ack may stay high waiting for req to fall
CNT_BITS, 16, width of the saturating status counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
aer  in  10  camera address bus; bundled data, stable before req rises
xsel  in  1  0 = row word (aer = y), 1 = column word (aer[9:1] = x, aer[0] = polarity)
req  in  1  asynchronous camera request
ack  out  1  registered handshake acknowledge to the camera
ev_valid  out  1  output event valid
ev_ready  in  1  downstream accept
ev_x  out  9  event column
ev_y  out  10  event row
ev_pol  out  1  event polarity
orphan_cnt  out  CNT_BITS  column words received with no preceding row (saturating)
timeout_cnt  out  CNT_BITS  handshake timeouts (saturating)

Behaviour:
- Reset: ack=0, ev_valid=0, ev_x/ev_y/ev_pol=0, both counters=0, row_valid=0, FSM=IDLE, synchroniser cleared. Reset mid-handshake drops ack on the reset edge. If req is still high after reset, the word is captured again.
- req_s is req delayed through SYNC_STAGES flops. aer and xsel are sampled only in IDLE when req_s=1, never combinationally.
- FSM states: IDLE, DECODE, ACK, RECOVER.
- IDLE: when req_s=1, latch aer and xsel into capture registers and go to DECODE.
- DECODE, row word: row_reg<=aer, row_valid<=1, go to ACK.
- DECODE, column word with row_valid=0: orphan_cnt+1 (saturating), word dropped, go to ACK.
- DECODE, column word with row_valid=1 and the slot free (ev_valid=0, or ev_ready=1 this cycle): load ev_x=aer[9:1], ev_y=row_reg, ev_pol=aer[0]; ev_valid<=1; go to ACK.
- DECODE, slot busy: remain in DECODE with ack low. This stalls the camera, so no event is ever lost.
- ack<=1 on entry to ACK. In ACK, when req_s=0: ack<=0, go to IDLE.
- In ACK, a timer counts cycles. On reaching TIMEOUT_CYCLES with req_s still 1: ack<=0, timeout_cnt+1 (saturating), go to RECOVER.
- RECOVER: ack=0; wait for req_s=0, then go to IDLE. This prevents recapturing the stale word.
- row_valid persists across column words, so one row may be followed by many columns (burst mode). A new row word overwrites row_reg.
- Output register: ev_valid clears on a cycle with ev_valid=1 and ev_ready=1 unless a new load occurs that same cycle. Data holds stable while ev_valid=1 and ev_ready=0.
- Latency: counting from the first clk edge that samples req=1, ack and ev_valid rise after SYNC_STAGES+2 edges (4 with defaults). Minimum handshake period is 2*SYNC_STAGES+3 cycles.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Add to dvs_ravens_pkg: AER_BITS=10, X_BITS=9, Y_BITS=10, typedef enum aer_rx_state_t {IDLE, DECODE, ACK, RECOVER}, typedef struct packed dvs_pix_event_t {x, y, pol}.
- Sub-module: aer_req_sync, a parameterised N-flop single-bit synchroniser with synchronous active-high reset.

Test Plan:
- Row aer=10'd37, then column aer={9'd100,1'b1}, ev_ready=1 -> one event x=100, y=37, pol=1; ack rises 4 cycles after req for each word.
- Row 5, then columns x=1, 2, 3 (pol 0) -> three events, all y=5, in order; orphan_cnt=0.
- Column word right after reset -> no event; orphan_cnt=1; ack completes the handshake normally.
- ev_ready=0, row 7, then two column words -> first event is held with stable data; the second word sees ack held low (stalled in DECODE) until ev_ready=1 for one cycle, then the second event loads.
- req held high for 1100 cycles after ack -> ack falls at the 1024th ACK cycle; timeout_cnt=1; no recapture until req falls and rises again.
- rst pulsed while ack=1 and ev_valid=1 -> next cycle ack=0, ev_valid=0, counters 0, row_valid cleared (a following column word counts as an orphan).
